// File: rtl/lcd_cmd_sequencer.sv
// HD44780-style 8-bit LCD write sequencer: power-up init ROM, then round-robin
// arbitration between two write requesters with full setup/E-pulse/exec timing.
module lcd_cmd_sequencer #(
  parameter int CNT_W   = 20,
  parameter int T_PWRUP = 750000,
  parameter int T_SETUP = 2,
  parameter int T_EPW   = 12,
  parameter int T_CMD   = 1900,
  parameter int T_LONG  = 76000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic       a_rs,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic       b_rs,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic [7:0] lcd_data,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       init_done,
  output logic       busy
);

  typedef enum logic [2:0] {S_PWRUP, S_SETUP, S_EHIGH, S_WAIT, S_IDLE} state_t;
  typedef enum logic {GRANT_A, GRANT_B} grant_t;

  localparam logic [CNT_W-1:0] TC_PWRUP = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] TC_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] TC_EPW   = CNT_W'(T_EPW - 1);
  localparam logic [CNT_W-1:0] TC_CMD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] TC_LONG  = CNT_W'(T_LONG - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             init_done_q, init_done_d;
  grant_t           last_grant_q, last_grant_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic             lcd_e_q, lcd_e_d;
  logic             busy_q, busy_d;
  logic             long_q, long_d;

  logic             accept_ok, grant_a, grant_b;
  logic             load, load_rs;
  logic [7:0]       load_data;
  logic [CNT_W-1:0] wait_tc;

  function automatic logic [7:0] init_rom(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_PWRUP;
      cnt_q        <= '0;
      idx_q        <= '0;
      init_done_q  <= 1'b0;
      last_grant_q <= GRANT_B;
      lcd_data_q   <= '0;
      lcd_rs_q     <= 1'b0;
      lcd_e_q      <= 1'b0;
      busy_q       <= 1'b1;
      long_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      init_done_q  <= init_done_d;
      last_grant_q <= last_grant_d;
      lcd_data_q   <= lcd_data_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_e_q      <= lcd_e_d;
      busy_q       <= busy_d;
      long_q       <= long_d;
    end
  end

  // Ready is only ever offered from IDLE; A wins ties unless it was granted last.
  always_comb begin
    accept_ok = (state_q == S_IDLE) && init_done_q;
    grant_a   = accept_ok && a_valid && (!b_valid || (last_grant_q == GRANT_B));
    grant_b   = accept_ok && b_valid && !grant_a;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    init_done_d  = init_done_q;
    last_grant_d = last_grant_q;
    lcd_data_d   = lcd_data_q;
    lcd_rs_d     = lcd_rs_q;
    long_d       = long_q;
    load         = 1'b0;
    load_rs      = 1'b0;
    load_data    = '0;
    wait_tc      = long_q ? TC_LONG : TC_CMD;

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == TC_PWRUP) begin
          load      = 1'b1;
          load_data = init_rom(2'd0);
        end
      end
      S_SETUP: begin
        if (cnt_q == TC_SETUP) begin
          state_d = S_EHIGH;
          cnt_d   = '0;
        end
      end
      S_EHIGH: begin
        if (cnt_q == TC_EPW) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_tc) begin
          if (!init_done_q && (idx_q != 2'd3)) begin
            idx_d     = idx_q + 2'd1;
            load      = 1'b1;
            load_data = init_rom(idx_q + 2'd1);
          end else begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            init_done_d = 1'b1;
          end
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (grant_a) begin
          last_grant_d = GRANT_A;
          load         = 1'b1;
          load_rs      = a_rs;
          load_data    = a_data;
        end else if (grant_b) begin
          last_grant_d = GRANT_B;
          load         = 1'b1;
          load_rs      = b_rs;
          load_data    = b_data;
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
      end
    endcase

    // Clear/home need the long execution wait; data writes never do.
    if (load) begin
      state_d    = S_SETUP;
      cnt_d      = '0;
      lcd_data_d = load_data;
      lcd_rs_d   = load_rs;
      long_d     = !load_rs && ((load_data == 8'h01) || (load_data == 8'h02) ||
                                (load_data == 8'h03));
    end
  end

  always_comb begin
    lcd_e_d = (state_d == S_EHIGH);
    busy_d  = (state_d != S_IDLE);
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign lcd_data  = lcd_data_q;
  assign lcd_e     = lcd_e_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer; a negedge monitor pops expected LCD
// transfers from a scoreboard queue and times each E pulse and execution wait.
module tb_lcd_cmd_sequencer;

  localparam int P_PWRUP = 20;
  localparam int P_SETUP = 2;
  localparam int P_EPW   = 4;
  localparam int P_CMD   = 10;
  localparam int P_LONG  = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, a_rs = 1'b0, b_valid = 1'b0, b_rs = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, lcd_e, lcd_rs, lcd_rw, init_done, busy;
  logic [7:0] lcd_data;

  lcd_cmd_sequencer #(
    .CNT_W  (20),
    .T_PWRUP(P_PWRUP),
    .T_SETUP(P_SETUP),
    .T_EPW  (P_EPW),
    .T_CMD  (P_CMD),
    .T_LONG (P_LONG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_rs     (a_rs),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_rs     (b_rs),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .lcd_data (lcd_data),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .init_done(init_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         twait;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rs, input logic [7:0] data, input int twait);
    exp_t e;
    e.rs = rs; e.data = data; e.twait = twait;
    sb.push_back(e);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38, P_CMD);
    push(1'b0, 8'h0C, P_CMD);
    push(1'b0, 8'h01, P_LONG);
    push(1'b0, 8'h06, P_CMD);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic count_pwrup(input string tag);
    int n = 0;
    while (!lcd_e && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
    check(tag, n, P_PWRUP + P_SETUP);
  endtask

  task automatic send(input logic use_b, input logic rs, input logic [7:0] data, input int twait);
    int n = 0;
    push(rs, data, twait);
    if (use_b) begin b_valid = 1'b1; b_rs = rs; b_data = data; end
    else       begin a_valid = 1'b1; a_rs = rs; a_data = data; end
    @(negedge clk);
    while (!(use_b ? b_ready : a_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {31'd0, (use_b ? b_ready : a_ready)}, 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Monitor: transfer content at E rise, E width at fall, wait until IDLE or next E.
  logic prev_e = 1'b0, meas = 1'b0;
  int   hi_cnt = 0, lo_cnt = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (rst) begin
      prev_e = 1'b0;
      meas   = 1'b0;
      hi_cnt = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        if (meas) begin
          check("wait_len_chain", lo_cnt - P_SETUP, cur.twait);
          meas = 1'b0;
        end
        check("sb_has_entry", {31'd0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          check("xfer_rs", {31'd0, lcd_rs}, {31'd0, cur.rs});
          check("xfer_data", {24'd0, lcd_data}, {24'd0, cur.data});
          check("xfer_rw", {31'd0, lcd_rw}, 32'd0);
        end
        hi_cnt = 1;
      end else if (lcd_e) begin
        hi_cnt++;
      end else if (prev_e) begin
        check("e_width", hi_cnt, P_EPW);
        lo_cnt = 1;
        meas   = 1'b1;
      end else if (meas) begin
        if (!busy) begin
          check("wait_len_idle", lo_cnt, cur.twait);
          check("init_done_at_idle", {31'd0, init_done}, 32'd1);
          meas = 1'b0;
        end else begin
          lo_cnt++;
        end
      end
      prev_e = lcd_e;
    end
  end

  initial begin
    int         n;
    int         a_idx, b_idx, acc, both;
    logic [3:0] ord;
    logic       took_a, took_b, prev_busy;
    logic [17:0] e_mask;
    int         busy_cnt;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
    check("rst_lcd_data", {24'd0, lcd_data}, 32'd0);
    check("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_lcd_rw", {31'd0, lcd_rw}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    push_init();
    rst = 1'b0;
    count_pwrup("pwrup_len");
    wait_idle("init_idle");
    check("init_done_after_init", {31'd0, init_done}, 32'd1);

    // Both requesters held valid: first tie after reset goes to A, then alternate.
    push(1'b1, 8'hA0, P_CMD);
    push(1'b1, 8'hB0, P_CMD);
    push(1'b1, 8'hA1, P_CMD);
    push(1'b1, 8'hB1, P_CMD);
    a_valid = 1'b1; a_rs = 1'b1; a_data = 8'hA0;
    b_valid = 1'b1; b_rs = 1'b1; b_data = 8'hB0;
    a_idx = 0; b_idx = 0; acc = 0; both = 0; ord = '0; n = 0;
    while (acc < 4 && n < 3000) begin
      @(negedge clk);
      took_a = a_ready;
      took_b = b_ready;
      if (took_a && took_b) both++;
      if (took_a || took_b) begin
        ord[acc] = took_b;
        acc++;
      end
      @(posedge clk); #1;
      n++;
      if (took_a) begin
        a_idx++;
        if (a_idx < 2) a_data = 8'hA1; else a_valid = 1'b0;
      end
      if (took_b) begin
        b_idx++;
        if (b_idx < 2) b_data = 8'hB1; else b_valid = 1'b0;
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("rr_accept_count", acc, 4);
    check("rr_order", {28'd0, ord}, 32'h0000000A);
    check("rr_two_readies", both, 0);
    wait_idle("rr_idle");

    // Single A data write: timing relative to the accept edge.
    push(1'b1, 8'h41, P_CMD);
    a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h41;
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("a41_ready", {31'd0, a_ready}, 32'd1);
    check("a41_b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    e_mask = '0;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clk);
      e_mask[cyc] = lcd_e;
      if (busy) busy_cnt++;
      if (cyc == 1) begin
        check("a41_rs", {31'd0, lcd_rs}, 32'd1);
        check("a41_data", {24'd0, lcd_data}, 32'h41);
        check("a41_ready_drop", {31'd0, a_ready}, 32'd0);
      end
      if (cyc == 17) check("a41_idle_at_17", {31'd0, busy}, 32'd0);
    end
    check("a41_e_window", {14'd0, e_mask}, 32'h00000078);
    check("a41_busy_cycles", busy_cnt, 16);
    @(posedge clk); #1;

    // Execution-wait selection through requester B.
    send(1'b1, 1'b0, 8'h01, P_LONG);
    wait_idle("b01_idle");
    send(1'b1, 1'b0, 8'h02, P_LONG);
    wait_idle("b02_idle");
    send(1'b1, 1'b0, 8'h80, P_CMD);
    wait_idle("b80_idle");
    send(1'b1, 1'b1, 8'h01, P_CMD);
    wait_idle("b_rs1_01_idle");

    // Reset while E is high, with a request already pending through the re-init.
    send(1'b0, 1'b1, 8'h55, P_CMD);
    n = 0;
    while (!lcd_e && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("e_high_before_rst", {31'd0, lcd_e}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    push_init();
    push(1'b0, 8'h80, P_CMD);
    a_valid = 1'b1; a_rs = 1'b0; a_data = 8'h80;
    @(posedge clk); #1;
    check("mid_rst_lcd_e", {31'd0, lcd_e}, 32'd0);
    check("mid_rst_lcd_data", {24'd0, lcd_data}, 32'd0);
    check("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    count_pwrup("pwrup_len_rerun");
    n = 0;
    prev_busy = 1'b1;
    @(negedge clk);
    while (!a_ready && n < 3000) begin
      prev_busy = busy;
      @(negedge clk);
      n++;
    end
    check("pending_ready", {31'd0, a_ready}, 32'd1);
    check("pending_init_done", {31'd0, init_done}, 32'd1);
    check("pending_first_idle", {30'd0, prev_busy, busy}, 32'd2);
    @(posedge clk); #1;
    a_valid = 1'b0;
    wait_idle("final_idle");
    @(posedge clk); #1;
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
- Owns the HD44780-style 8-bit LCD bus (data, E, RS, RW).
- Runs the power-up init sequence, then arbitrates write requests from two requesters: A = CPU/peripheral bus, B = keypad path.
- Generates the setup, E-pulse and execution-wait timing for every transfer, so requesters never touch LCD timing.
- Sits between the MCU peripheral interconnect/keypad scanner and the LCD pins.

Parameters:
- CNT_W, 20, width of the internal timing counter.
- T_PWRUP, 750000, cycles E held low after reset before the first init command (15 ms at 50 MHz).
- T_SETUP, 2, cycles RS/data are stable with E low before E rises.
- T_EPW, 12, cycles E is held high.
- T_CMD, 1900, post-E execution wait for normal commands and data (about 38 us).
- T_LONG, 76000, post-E execution wait for clear and home (about 1.52 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- a_valid  in  1  requester A has a write pending
- a_rs  in  1  requester A register select (0 = command, 1 = data)
- a_data  in  8  requester A byte
- a_ready  out  1  requester A transfer accepted this cycle
- b_valid  in  1  requester B has a write pending
- b_rs  in  1  requester B register select
- b_data  in  8  requester B byte
- b_ready  out  1  requester B transfer accepted this cycle
- lcd_data  out  8  LCD data bus
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; tied 0 (write only)
- init_done  out  1  init sequence complete
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - lcd_data=0, lcd_e=0, lcd_rs=0, lcd_rw=0, init_done=0, busy=1.
  - Counter=0, init index=0, last_grant=B, state=PWRUP.
- Reset mid-operation (including while E is high): all of the above apply at that edge, and the full init sequence reruns.
- States: PWRUP, SETUP, EHIGH, WAIT, IDLE.
  - PWRUP: count T_PWRUP cycles, then load init entry 0 and go to SETUP.
  - Init ROM, all rs=0: 0x38 (8-bit, 2-line, 5x8), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry increment, no shift).
- Transfer timing. For each transfer, lcd_rs and lcd_data are registered at the load edge and held unchanged until the next load.
  - SETUP: lcd_e=0 for exactly T_SETUP cycles.
  - EHIGH: lcd_e=1 for exactly T_EPW cycles.
  - WAIT: lcd_e=0 for exactly Twait cycles, then return.
  - Twait = T_LONG if rs=0 and data is 0x01, 0x02 or 0x03; otherwise T_CMD. So rs=1 with data 0x01 uses T_CMD.
- Leaving WAIT:
  - During init with more ROM entries: load the next entry and go to SETUP.
  - After the last init entry: go to IDLE; init_done rises in the same cycle as the transition to IDLE and stays 1 until reset.
- Occupancy: T_SETUP + T_EPW + Twait cycles from load edge to the first IDLE cycle.
- Handshake:
  - a_ready/b_ready are combinational and only possible when state=IDLE and init_done=1.
  - A transfer occurs on the edge where valid and ready are both 1; the sequencer latches rs/data and goes to SETUP.
  - At most one ready is high per cycle.
  - Requesters hold rs/data stable while valid=1 and ready=0; valid may not drop before acceptance.
  - Requests pending before init_done stay pending, with no drop and no ready.
- Arbitration, round-robin:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates on each accepted transfer.
  - After reset, A wins the first tie.
- busy = (state != IDLE), registered with the state. busy=0 in IDLE even when init_done=0 cannot occur, because IDLE is only reached after init.
- Counter compares are done at full CNT_W width; parameters must fit in CNT_W. Terminal count is value-1, so each phase lasts exactly its parameter in cycles.

Test Plan (sim params: T_PWRUP=20, T_SETUP=2, T_EPW=4, T_CMD=10, T_LONG=40):
- Release rst -> lcd_e=0 for 20 cycles. Then four E pulses, each 4 cycles high, with lcd_data 0x38, 0x0C, 0x01, 0x06 and lcd_rs=0. The gap after 0x01 is 40 cycles and the others are 10. init_done rises when busy falls.
- After init, a_valid=1, a_rs=1, a_data=0x41 -> a_ready high for 1 cycle. lcd_rs=1 and lcd_data=0x41 from the next cycle. lcd_e high for cycles 3-6 after accept. busy high for 16 cycles.
- a_valid and b_valid held high continuously with distinct bytes -> accepted order is A, B, A, B. Never two readies in one cycle.
- Wait-length selection via B:
  - rs=0, data 0x01 -> 40-cycle wait.
  - rs=0, data 0x02 -> 40-cycle wait.
  - rs=0, data 0x80 -> 10-cycle wait.
  - rs=1, data 0x01 -> 10-cycle wait.
- Assert rst during EHIGH of a user write -> at that edge lcd_e=0, lcd_data=0, init_done=0. The PWRUP wait and full init sequence repeat.
- Assert a_valid during init -> a_ready stays 0 until init_done. The request is accepted in the first IDLE cycle with the held data.
